// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus decoder and its slot decode.
package periph_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} bus_state_t;

  localparam int unsigned SLOT_LED  = 1;
  localparam int unsigned SLOT_SPI  = 2;
  localparam int unsigned SLOT_RAM  = 3;
  localparam int unsigned SLOT_IN   = 4;
  localparam int unsigned SLOT_UART = 5;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam logic [7:0]  ERR_CNT_MAX      = 8'hFF;

endpackage

// File: rtl/bus_slot_decoder.sv
// Combinational slot -> one-hot-low select decode; unpopulated slots decode to all ones.
module bus_slot_decoder #(
  parameter int unsigned         N_SLAVES   = 16,
  parameter int unsigned         SLOT_W     = 4,
  parameter logic [N_SLAVES-1:0] SLAVE_MASK = '1
) (
  input  logic [SLOT_W-1:0]   slot,
  output logic [N_SLAVES-1:0] sel_n,
  output logic                valid
);

  always_comb begin
    sel_n = '1;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (32'(slot) == i && SLAVE_MASK[i]) sel_n[i] = 1'b0;
    end
    valid = ~&sel_n;
  end

endmodule

// File: rtl/periph_bus_decoder.sv
// Address-slot decoder with request/ready handshake, per-access watchdog and sticky error status.
module periph_bus_decoder
  import periph_bus_pkg::*;
#(
  parameter int unsigned         N_SLAVES   = 16,
  parameter int unsigned         SEL_MSB    = 31,
  parameter int unsigned         SEL_LSB    = 28,
  parameter logic [N_SLAVES-1:0] SLAVE_MASK = 16'h003E,
  parameter int unsigned         TIMEOUT    = 255,
  parameter logic [31:0]         ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [31:0]            cpu_adr,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_err,
  output logic [N_SLAVES-1:0]    cs_n,
  output logic                   slv_we,
  input  logic [N_SLAVES*32-1:0] slv_rdata,
  input  logic [N_SLAVES-1:0]    slv_ready,
  input  logic                   err_clr,
  output logic                   err_flag,
  output logic [31:0]            err_adr,
  output logic [7:0]             err_cnt
);

  localparam int unsigned SLOT_W = SEL_MSB - SEL_LSB + 1;

  bus_state_t          state;
  logic [SLOT_W-1:0]   slot_q;
  logic [31:0]         adr_q;
  logic [15:0]         wait_cnt;
  logic [N_SLAVES-1:0] dec_sel_n;
  logic                dec_valid;
  logic [31:0]         sel_rdata;
  logic                sel_ready;

  bus_slot_decoder #(
    .N_SLAVES  (N_SLAVES),
    .SLOT_W    (SLOT_W),
    .SLAVE_MASK(SLAVE_MASK)
  ) u_dec (
    .slot (cpu_adr[SEL_MSB:SEL_LSB]),
    .sel_n(dec_sel_n),
    .valid(dec_valid)
  );

  // Only the latched slot's ready and data are visible; other slots are ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (32'(slot_q) == i) begin
        sel_rdata = slv_rdata[32*i +: 32];
        sel_ready = slv_ready[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      slot_q    <= '0;
      adr_q     <= '0;
      wait_cnt  <= '0;
      cs_n      <= '1;
      slv_we    <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            adr_q    <= cpu_adr;
            slot_q   <= cpu_adr[SEL_MSB:SEL_LSB];
            slv_we   <= cpu_we;
            wait_cnt <= '0;
            if (dec_valid) begin
              state <= WAIT;
              cs_n  <= dec_sel_n;
            end else begin
              state     <= ERR;
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= ERR_DATA;
            end
          end
        end
        WAIT: begin
          if (sel_ready) begin
            if (!slv_we) cpu_rdata <= sel_rdata;
            state     <= RESP;
            cs_n      <= '1;
            cpu_ready <= 1'b1;
          end else if (wait_cnt == 16'(TIMEOUT)) begin
            state     <= ERR;
            cs_n      <= '1;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= ERR_DATA;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // An error in the same cycle as err_clr restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_flag <= 1'b0;
      err_adr  <= '0;
      err_cnt  <= '0;
    end else if (state == ERR) begin
      err_flag <= 1'b1;
      err_adr  <= adr_q;
      if (err_clr)                     err_cnt <= 8'd1;
      else if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end
  end

endmodule

// File: doc/periph_bus_decoder.md
Name: periph_bus_decoder

Overview:
- Parametrised successor to the fixed 4-to-16 chip-select decoder.
- Decodes a configurable address slice into N active-low peripheral selects.
- Runs a request/ready handshake per access, with per-slave wait states and a watchdog timeout.
- Returns registered read data and reports bus errors for unmapped or unresponsive slots.
- Sits between the core's data port and the memory-mapped peripherals (RAM, LED register, SPI, input register, UART).

Parameters:
- N_SLAVES, 16: number of select lines; must be ≤ 2**(SEL_MSB-SEL_LSB+1).
- SEL_MSB, 31: top address bit of the slot field.
- SEL_LSB, 28: bottom address bit of the slot field.
- SLAVE_MASK, 16'h003E: bit i=1 means slot i is populated (slots 1–5).
- TIMEOUT, 255: maximum wait cycles before a bus error; range 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an error response.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- cpu_req, in, 1: access request; held until cpu_ready.
- cpu_we, in, 1: 1=write, 0=read.
- cpu_adr, in, 32: byte address.
- cpu_rdata, out, 32: registered read data; valid when cpu_ready=1.
- cpu_ready, out, 1: one-cycle completion pulse.
- cpu_err, out, 1: qualifies cpu_ready; 1=bus error.
- cs_n, out, N_SLAVES: active-low selects, one-hot-low or all ones.
- slv_we, out, 1: registered copy of cpu_we, valid while any cs_n is low.
- slv_rdata, in, N_SLAVES*32: flattened slave read buses; slot i occupies [32*i+31:32*i].
- slv_ready, in, N_SLAVES: per-slave done strobe.
- err_clr, in, 1: clears the error status.
- err_flag, out, 1: sticky error flag.
- err_adr, out, 32: address of the most recent error.
- err_cnt, out, 8: saturating error count.

Behaviour:
- Reset (synchronous): state=IDLE; cs_n all ones; cpu_ready=0; cpu_err=0; cpu_rdata=0; slv_we=0; wait counter=0; err_flag=0; err_adr=0; err_cnt=0.
- Reset mid-transaction aborts the access: no ready pulse, and cs_n returns high on the following edge.
- Slot decode: slot = cpu_adr[SEL_MSB:SEL_LSB].
  - Slot is valid iff slot < N_SLAVES and SLAVE_MASK[slot]=1.
- States: IDLE, WAIT, RESP, ERR.
- IDLE:
  - On cpu_req=1, latch address, we and slot.
  - Valid slot → next WAIT; cs_n[slot]=0 from the next cycle; slv_we=cpu_we.
  - Invalid slot → next ERR; no cs_n asserted.
- WAIT:
  - cs_n[slot] held low; the wait counter increments each cycle.
  - Only slv_ready[slot] is observed; ready from any other slot is ignored.
  - slv_ready[slot]=1 → capture slv_rdata slot word into cpu_rdata (reads only; writes leave cpu_rdata unchanged). Next state RESP; cs_n returns to all ones.
  - Counter == TIMEOUT with no ready → next ERR; cs_n returns to all ones.
  - Ready in the same cycle as the timeout: ready wins, no error.
- RESP: cpu_ready=1, cpu_err=0 for exactly one cycle; next IDLE.
- ERR:
  - cpu_ready=1, cpu_err=1, cpu_rdata=ERR_DATA (reads and writes) for one cycle.
  - Set err_flag; load err_adr with the latched address; err_cnt increments, saturating at 255.
  - Next IDLE.
- Latency (cpu_req sampled at edge 0):
  - Zero-wait slave (ready in its first selected cycle): cs_n low in cycle 1, cpu_ready in cycle 2.
  - Each slave wait cycle adds one cycle.
  - Unmapped access: cpu_ready in cycle 1.
  - Timeout: cpu_ready in cycle TIMEOUT+2.
- Back-to-back: the earliest next acceptance is the cycle after the ready pulse, so IDLE is always visited for at least one cycle.
- cpu_adr and cpu_we changes after acceptance are ignored until IDLE.
- err_clr: clears err_flag and err_cnt (err_adr is kept). If err_clr and an ERR state occur in the same cycle, the result is err_flag=1 and err_cnt=1.
- Invariant: at most one cs_n bit is low; cs_n is never low outside WAIT.

Decomposition:
- Shared package periph_bus_pkg:
  - bus_state_t enum {IDLE, WAIT, RESP, ERR}.
  - Default slot constants: SLOT_LED=1, SLOT_SPI=2, SLOT_RAM=3, SLOT_IN=4, SLOT_UART=5.
  - Default ERR_DATA.
- One sub-module, bus_slot_decoder: purely combinational parametrised slot → one-hot-low decode plus the valid bit. It generalises decod_4_16 and is reusable elsewhere.
- Handshake FSM, counters and error registers live in the parent.

Test Plan:
1. Read slot 3, addr 0x3000_0010, slave ready on its first selected cycle with data 0x1234_5678 → cs_n=16'hFFF7 in cycle 1; cpu_ready, cpu_err=0, cpu_rdata=0x1234_5678 in cycle 2.
2. Write slot 2, addr 0x2000_0001, slave delays ready by 3 cycles → cs_n[2] low for 4 cycles; slv_we=1; cpu_ready in cycle 5; cpu_rdata unchanged.
3. Read unmapped slot 0, addr 0x0000_0000 → no cs_n low; cpu_ready, cpu_err=1 in cycle 1; cpu_rdata=0xDEAD_BEEF; err_flag=1; err_adr=0; err_cnt=1.
4. TIMEOUT=4, read slot 5, no ready → cs_n[5] low cycles 1–5; error response in cycle 6; err_adr=0x5000_0000. Repeat with ready at the timeout cycle → normal response, no error.
5. Slot 1 selected while slv_ready[4]=1 only → no response; still waiting. Then assert reset mid-WAIT → next cycle cs_n=all ones, no ready pulse, err_cnt=0.
6. 300 consecutive unmapped accesses → err_cnt saturates at 255. Then err_clr in the same cycle as an error → err_flag=1, err_cnt=1.
